// File: rtl/quadrature_window_sampler.sv
// -----------------------------------------------------------------------------
// quadrature_window_sampler
//
// Purpose
//   Sequences readout of the free-running quadrature mul-acc. On ADC
//   zero-crossings it snapshots the SIN/COS accumulators. It then differences
//   them over a programmable number of half-periods. Each finished window is
//   delivered as (dSIN, dCOS, CE-cycle count) on a valid/ready port. The block
//   sits between the mul-acc and the phase/amplitude post-processing.
//
// Optional feature
//   QWS_TIMEOUT_EN  when defined, a window (or a wait for the arming crossing)
//                   that reaches TIMEOUT_CYCLES CE cycles without a closing
//                   crossing emits a zero result with o_timeout=1 and re-arms.
//                   When undefined, ARM/MEASURE wait indefinitely and
//                   o_timeout is always 0.
//
// Ports
//   i_clk           clock
//   i_reset         synchronous reset, active-high
//   i_ce            clock enable shared with the mul-acc; qualifies all
//                   counting, sampling and state changes
//   i_enable        1 = run windows, 0 = return to IDLE
//   i_half_periods  zero-crossings per window (0 is treated as 1), sampled at
//                   window start only
//   i_sin_acc       mul-acc SIN result (signed, free-running)
//   i_cos_acc       mul-acc COS result (signed, free-running)
//   i_zero_cross    mul-acc ADC zero-crossing, aligned with the accumulators
//   o_sin           SIN accumulator delta over the last window
//   o_cos           COS accumulator delta over the last window
//   o_cycles        CE cycles spanned by the last window (saturating)
//   o_valid         result available
//   i_ready         consumer accepts the result when o_valid && i_ready
//   o_overrun       sticky: an unconsumed result was overwritten
//                   (cleared by reset or while IDLE)
//   o_timeout       last result was ended by the timeout
// -----------------------------------------------------------------------------
module quadrature_window_sampler #(
  parameter int RESULT_WIDTH   = 32,
  parameter int CYCLE_WIDTH    = 24,
  parameter int CNT_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_ce,
  input  logic                    i_enable,
  input  logic [CNT_WIDTH-1:0]    i_half_periods,
  input  logic [RESULT_WIDTH-1:0] i_sin_acc,
  input  logic [RESULT_WIDTH-1:0] i_cos_acc,
  input  logic                    i_zero_cross,
  output logic [RESULT_WIDTH-1:0] o_sin,
  output logic [RESULT_WIDTH-1:0] o_cos,
  output logic [CYCLE_WIDTH-1:0]  o_cycles,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_overrun,
  output logic                    o_timeout
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

  localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH:0]     XCNT_ONE  = (CNT_WIDTH + 1)'(1);
  localparam logic [CYCLE_WIDTH-1:0] CYCLE_ONE = CYCLE_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]              r_state;
  logic [RESULT_WIDTH-1:0] r_base_sin;
  logic [RESULT_WIDTH-1:0] r_base_cos;
  logic [CNT_WIDTH-1:0]    r_xcnt;      // crossings seen in the current window
  logic [CNT_WIDTH-1:0]    r_n;         // crossings that close the current window
  logic [CYCLE_WIDTH-1:0]  r_ccnt;      // CE cycles elapsed in the current window

  logic [RESULT_WIDTH-1:0] r_out_sin;
  logic [RESULT_WIDTH-1:0] r_out_cos;
  logic [CYCLE_WIDTH-1:0]  r_out_cycles;
  logic                    r_out_valid;
  logic                    r_overrun;
  logic                    r_timeout;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic                    w_event;
  logic [CNT_WIDTH-1:0]    w_n_load;
  logic [CNT_WIDTH:0]      w_xcnt_p1;
  logic [CYCLE_WIDTH-1:0]  w_ccnt_inc;
  logic                    w_close;
  logic                    w_timeout_hit;
  logic                    w_new_result;
  logic [RESULT_WIDTH-1:0] w_delta_sin;
  logic [RESULT_WIDTH-1:0] w_delta_cos;
  logic [CYCLE_WIDTH-1:0]  w_result_cycles;

  // A crossing only counts when the mul-acc is actually advancing.
  assign w_event = i_ce && i_zero_cross;

  // A window of zero crossings would be meaningless; clamp it to one.
  assign w_n_load = (i_half_periods == '0) ? CNT_ONE : i_half_periods;

  // One bit wider so the compare cannot wrap when r_n is all-ones.
  assign w_xcnt_p1 = {1'b0, r_xcnt} + XCNT_ONE;

  // Saturating cycle count including the current CE cycle.
  assign w_ccnt_inc = (&r_ccnt) ? r_ccnt : (r_ccnt + CYCLE_ONE);

  assign w_close = i_ce && i_enable && (r_state == ST_MEASURE) && w_event &&
                   (w_xcnt_p1 == {1'b0, r_n});

  // Differences are taken modulo 2**RESULT_WIDTH, so an accumulator wrap
  // inside the window still yields the correct delta.
  assign w_delta_sin = i_sin_acc - r_base_sin;
  assign w_delta_cos = i_cos_acc - r_base_cos;

`ifdef QWS_TIMEOUT_EN
  localparam logic [CYCLE_WIDTH-1:0] TIMEOUT_LIMIT = CYCLE_WIDTH'(TIMEOUT_CYCLES);

  // A closing crossing in the same cycle wins over the timeout. An arming
  // crossing in ARM also wins, because it starts a fresh window.
  assign w_timeout_hit = i_ce && i_enable && !w_close &&
                         ((r_state == ST_MEASURE) ||
                          ((r_state == ST_ARM) && !w_event)) &&
                         (w_ccnt_inc >= TIMEOUT_LIMIT);
  assign w_result_cycles = w_close ? w_ccnt_inc : TIMEOUT_LIMIT;
`else
  // Without the timeout feature the limit has no role.
  logic [31:0] w_unused_timeout_cycles;
  assign w_unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign w_timeout_hit   = 1'b0;
  assign w_result_cycles = w_ccnt_inc;
`endif

  assign w_new_result = w_close || w_timeout_hit;

  // ---------------------------------------------------------------------------
  // Window sequencer: state, snapshots and counters. Everything here advances
  // only on CE cycles.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_base_sin <= '0;
      r_base_cos <= '0;
      r_xcnt     <= '0;
      r_n        <= '0;
      r_ccnt     <= '0;
    end else if (i_ce) begin
      if (!i_enable) begin
        // Dropping enable discards the open window. Results already
        // delivered stay on the output port until consumed.
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_ARM;
            r_ccnt  <= '0;
          end

          ST_ARM: begin
            if (w_event) begin
              r_base_sin <= i_sin_acc;
              r_base_cos <= i_cos_acc;
              r_xcnt     <= '0;
              r_ccnt     <= '0;
              r_n        <= w_n_load;
              r_state    <= ST_MEASURE;
            end else if (w_timeout_hit) begin
              r_ccnt <= '0;
            end else begin
              r_ccnt <= w_ccnt_inc;
            end
          end

          ST_MEASURE: begin
            if (w_close) begin
              // Consecutive windows share the closing crossing as their
              // boundary, so the next window starts right here.
              r_base_sin <= i_sin_acc;
              r_base_cos <= i_cos_acc;
              r_xcnt     <= '0;
              r_ccnt     <= '0;
              r_n        <= w_n_load;
            end else if (w_timeout_hit) begin
              r_xcnt  <= '0;
              r_ccnt  <= '0;
              r_state <= ST_ARM;
            end else begin
              r_ccnt <= w_ccnt_inc;
              if (w_event) begin
                r_xcnt <= r_xcnt + CNT_ONE;
              end
            end
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result register and valid/ready handshake. The handshake runs on every
  // clock, whether or not CE is active.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_sin    <= '0;
      r_out_cos    <= '0;
      r_out_cycles <= '0;
      r_out_valid  <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      if (w_new_result) begin
        r_out_sin    <= w_close ? w_delta_sin : '0;
        r_out_cos    <= w_close ? w_delta_cos : '0;
        r_out_cycles <= w_result_cycles;
        r_timeout    <= w_timeout_hit;
        r_out_valid  <= 1'b1;
        // A result accepted in this same cycle is not lost, so only an
        // unaccepted one counts as overrun. The latest result wins.
        if (r_out_valid && !i_ready) begin
          r_overrun <= 1'b1;
        end
      end else begin
        if (r_out_valid && i_ready) begin
          r_out_valid <= 1'b0;
        end
        if (r_state == ST_IDLE) begin
          r_overrun <= 1'b0;
        end
      end
    end
  end

  assign o_sin     = r_out_sin;
  assign o_cos     = r_out_cos;
  assign o_cycles  = r_out_cycles;
  assign o_valid   = r_out_valid;
  assign o_overrun = r_overrun;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_quadrature_window_sampler.sv
// -----------------------------------------------------------------------------
// tb_quadrature_window_sampler
//
// Directed bench for quadrature_window_sampler. Expected results are pushed
// to a scoreboard queue as each closing stimulus is driven. They are popped
// and compared when the DUT presents o_valid. Outputs are sampled 1 ns after
// the rising edge. The timeout scenario is exercised when QWS_TIMEOUT_EN is
// defined for the build.
// -----------------------------------------------------------------------------
module tb_quadrature_window_sampler;

  localparam int RW = 32;
  localparam int CW = 24;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ce;
  logic          enable;
  logic [NW-1:0] half_periods;
  logic [RW-1:0] sin_acc;
  logic [RW-1:0] cos_acc;
  logic          zero_cross;
  logic [RW-1:0] out_sin;
  logic [RW-1:0] out_cos;
  logic [CW-1:0] out_cycles;
  logic          out_valid;
  logic          out_ready;
  logic          overrun;
  logic          timeout;

  always #5 clk = ~clk;

  quadrature_window_sampler #(
    .RESULT_WIDTH  (RW),
    .CYCLE_WIDTH   (CW),
    .CNT_WIDTH     (NW),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_ce          (ce),
    .i_enable      (enable),
    .i_half_periods(half_periods),
    .i_sin_acc     (sin_acc),
    .i_cos_acc     (cos_acc),
    .i_zero_cross  (zero_cross),
    .o_sin         (out_sin),
    .o_cos         (out_cos),
    .o_cycles      (out_cycles),
    .o_valid       (out_valid),
    .i_ready       (out_ready),
    .o_overrun     (overrun),
    .o_timeout     (timeout)
  );

  typedef struct {
    logic [RW-1:0] sin_d;
    logic [RW-1:0] cos_d;
    logic [CW-1:0] cycles;
    logic          to;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [RW-1:0] s, input logic [RW-1:0] c,
                      input logic [CW-1:0] cy, input logic to);
    exp_t e;
    e.sin_d  = s;
    e.cos_d  = c;
    e.cycles = cy;
    e.to     = to;
    sb.push_back(e);
  endtask

  // Compare the presented result against the oldest scoreboard entry.
  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb_underflow observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"},   64'(out_valid),  64'(1'b1));
      check({tag, "_sin"},     64'(out_sin),    64'(e.sin_d));
      check({tag, "_cos"},     64'(out_cos),    64'(e.cos_d));
      check({tag, "_cycles"},  64'(out_cycles), 64'(e.cycles));
      check({tag, "_timeout"}, 64'(timeout),    64'(e.to));
    end
  endtask

  // One clock: drive CE/crossing, let the edge happen, sample 1 ns later.
  task automatic step(input logic c, input logic z);
    ce         = c;
    zero_cross = z;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b1, 1'b0);
  endtask

  task automatic ev(input logic [RW-1:0] s, input logic [RW-1:0] c);
    sin_acc = s;
    cos_acc = c;
    step(1'b1, 1'b1);
  endtask

  // Accept on a non-CE cycle so window counting is unaffected.
  task automatic accept(input string tag);
    out_ready = 1'b1;
    step(1'b0, 1'b0);
    check({tag, "_accepted"}, 64'(out_valid), 64'(1'b0));
    out_ready = 1'b0;
  endtask

  initial begin
    int n_wait;
    reset        = 1'b1;
    ce           = 1'b1;
    enable       = 1'b0;
    half_periods = '0;
    sin_acc      = '0;
    cos_acc      = '0;
    zero_cross   = 1'b0;
    out_ready    = 1'b0;

    // Reset state
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    reset = 1'b0;
    check("rst_valid",   64'(out_valid),  64'(0));
    check("rst_sin",     64'(out_sin),    64'(0));
    check("rst_cycles",  64'(out_cycles), 64'(0));
    check("rst_overrun", 64'(overrun),    64'(0));
    check("rst_timeout", 64'(timeout),    64'(0));

    // 1: two half-periods, crossings 10 CE cycles apart
    half_periods = 8'd2;
    enable       = 1'b1;
    step(1'b1, 1'b0);
    ev(32'd100, -32'sd50);
    idle(9);
    ev(32'd300, 32'd0);
    check("t1_mid_valid", 64'(out_valid), 64'(0));
    idle(9);
    push(32'd400, 32'd200, 24'd20, 1'b0);
    ev(32'd500, 32'd150);
    check_result("t1");
    accept("t1");
    enable = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("t1_idle_hold_sin", 64'(out_sin), 64'(400));

    // 2: accumulator wrap across the window
    half_periods = 8'd1;
    enable       = 1'b1;
    step(1'b1, 1'b0);
    ev(32'h7FFF_FFF0, 32'd0);
    idle(4);
    push(32'h20, 32'd5, 24'd5, 1'b0);
    ev(32'h8000_0010, 32'd5);
    check_result("t2");
    accept("t2");

    // 3: unconsumed result overwritten, then ENABLE=0 clears OVERRUN
    idle(2);
    push(32'h100, 32'd10, 24'd3, 1'b0);
    ev(32'h8000_0110, 32'd15);
    check_result("t3a");
    check("t3a_overrun", 64'(overrun), 64'(0));
    idle(1);
    push(32'h100, 32'd5, 24'd2, 1'b0);
    ev(32'h8000_0210, 32'd20);
    check_result("t3b");
    check("t3b_overrun", 64'(overrun), 64'(1));
    enable = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("t3_idle_overrun", 64'(overrun),   64'(0));
    check("t3_idle_valid",   64'(out_valid), 64'(1));
    accept("t3");

    // 4: accept in the same cycle a new result arrives
    enable = 1'b1;
    step(1'b1, 1'b0);
    ev(32'd10, 32'd20);
    idle(1);
    push(32'd20, 32'd30, 24'd2, 1'b0);
    ev(32'd30, 32'd50);
    check_result("t4a");
    idle(1);
    out_ready = 1'b1;
    push(32'd10, 32'd5, 24'd2, 1'b0);
    ev(32'd40, 32'd55);
    check_result("t4b");
    check("t4_overrun", 64'(overrun), 64'(0));
    step(1'b0, 1'b0);
    check("t4_drained", 64'(out_valid), 64'(0));
    out_ready = 1'b0;

    // 5: HALF_PERIODS=0, mid-window change 1->3, CE gaps
    enable = 1'b0;
    step(1'b1, 1'b0);
    half_periods = 8'd0;
    enable       = 1'b1;
    step(1'b1, 1'b0);
    ev(32'd0, 32'd0);
    push(32'd7, 32'd3, 24'd1, 1'b0);
    ev(32'd7, 32'd3);
    check_result("t5a");
    accept("t5a");
    half_periods = 8'd1;
    idle(2);
    half_periods = 8'd3;
    idle(1);
    push(32'd10, 32'd1, 24'd4, 1'b0);
    ev(32'd17, 32'd4);
    check_result("t5b");
    accept("t5b");
    ev(32'd20, 32'd5);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    idle(1);
    ev(32'd30, 32'd6);
    check("t5c_mid_valid", 64'(out_valid), 64'(0));
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    push(32'd23, 32'd5, 24'd4, 1'b0);
    ev(32'd40, 32'd9);
    check_result("t5c");

    // 6a: RESET mid-window with a result pending
    ev(32'd50, 32'd10);
    reset = 1'b1;
    step(1'b1, 1'b0);
    reset = 1'b0;
    check("t6_rst_valid",   64'(out_valid),  64'(0));
    check("t6_rst_sin",     64'(out_sin),    64'(0));
    check("t6_rst_cos",     64'(out_cos),    64'(0));
    check("t6_rst_cycles",  64'(out_cycles), 64'(0));
    check("t6_rst_overrun", 64'(overrun),    64'(0));
    half_periods = 8'd1;
    step(1'b1, 1'b0);
    ev(32'd60, 32'd0);
    check("t6_arm_valid", 64'(out_valid), 64'(0));
    push(32'd5, 32'd1, 24'd1, 1'b0);
    ev(32'd65, 32'd1);
    check_result("t6_rearm");
    accept("t6_rearm");

    // 6b: no crossings after arming
    enable = 1'b0;
    step(1'b1, 1'b0);
    enable = 1'b1;
    step(1'b1, 1'b0);
    ev(32'd1000, 32'd2000);
`ifdef QWS_TIMEOUT_EN
    n_wait = 0;
    while (n_wait < 150 && out_valid !== 1'b1) begin
      step(1'b1, 1'b0);
      n_wait++;
    end
    check("t6_timeout_latency", 64'(n_wait), 64'(100));
    push(32'd0, 32'd0, 24'd100, 1'b1);
    check_result("t6_timeout");
    check("t6_timeout_overrun", 64'(overrun), 64'(0));
    accept("t6_timeout");
`else
    n_wait = 150;
    idle(n_wait);
    check("t6_no_timeout_valid", 64'(out_valid), 64'(0));
    check("t6_no_timeout_flag",  64'(timeout),   64'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
